// File: rtl/pcileech_bar_func_dispatch.sv
// BAR access dispatcher: routes BAR writes/reads to per-function BAR
// blocks and merges their read completions into one completion stream.
module pcileech_bar_func_dispatch #(
  parameter int NUM_FUNC    = 8,
  parameter int FSEL_LSB    = 29,
  parameter int CTX_W       = 88,
  parameter int OUTST_DEPTH = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                      clk_pcie,
  input  logic                      rst_n,
  input  logic [NUM_FUNC-1:0]       func_enable,
  input  logic [31:0]               req_wr_addr,
  input  logic [3:0]                req_wr_be,
  input  logic [31:0]               req_wr_data,
  input  logic                      req_wr_valid,
  input  logic [CTX_W-1:0]          req_rd_ctx,
  input  logic [31:0]               req_rd_addr,
  input  logic                      req_rd_valid,
  output logic                      req_rd_ready,
  output logic [CTX_W-1:0]          rsp_ctx,
  output logic [31:0]               rsp_data,
  output logic                      rsp_valid,
  output logic [31:0]               f_wr_addr,
  output logic [3:0]                f_wr_be,
  output logic [31:0]               f_wr_data,
  output logic [NUM_FUNC-1:0]       f_wr_valid,
  output logic [CTX_W-1:0]          f_rd_ctx,
  output logic [31:0]               f_rd_addr,
  output logic [NUM_FUNC-1:0]       f_rd_valid,
  input  logic [NUM_FUNC*CTX_W-1:0] f_rsp_ctx,
  input  logic [NUM_FUNC*32-1:0]    f_rsp_data,
  input  logic [NUM_FUNC-1:0]       f_rsp_valid,
  output logic [15:0]               stat_wr_drop,
  output logic [15:0]               stat_rd_err,
  output logic [15:0]               stat_timeout
);

  localparam int NR = NUM_FUNC + 1;
  localparam int IW = $clog2(NR);
  localparam int QA = $clog2(OUTST_DEPTH);
  localparam int RA = $clog2(RSP_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [31:0] FMASK = ~(32'h7 << FSEL_LSB);

  logic [7:0]          en8;
  logic [2:0]          wr_fsel;
  logic [2:0]          rd_fsel;
  logic                wr_hit;
  logic                rd_hit;
  logic                rd_acc;
  logic [7:0]          wr_oh;
  logic [7:0]          rd_oh;

  logic [NUM_FUNC-1:0] q_full;
  logic [NUM_FUNC-1:0] discard;
  logic [NUM_FUNC-1:0] tmo;
  logic [NUM_FUNC-1:0] drop;
  logic [NUM_FUNC-1:0] rf_pop;
  logic [NR-1:0]       req;
  logic [CTX_W-1:0]    cand_ctx [NR];
  logic [31:0]         cand_dat [NR];

  logic                slot_v;
  logic [CTX_W-1:0]    slot_ctx;
  logic                gnt_v;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       rr_ptr;
  logic [4:0]          err_inc;
  logic [4:0]          tmo_inc;

  // Unimplemented function slots read as disabled, which folds the
  // fsel < NUM_FUNC test into the enable lookup.
  always_comb begin
    en8 = '0;
    en8[NUM_FUNC-1:0] = func_enable;
  end

  assign wr_fsel = req_wr_addr[FSEL_LSB+2:FSEL_LSB];
  assign rd_fsel = req_rd_addr[FSEL_LSB+2:FSEL_LSB];
  assign wr_hit  = en8[wr_fsel];
  assign rd_hit  = en8[rd_fsel];
  assign wr_oh   = 8'b1 << wr_fsel;
  assign rd_oh   = 8'b1 << rd_fsel;

  assign req_rd_ready = ~|q_full & ~slot_v;
  assign rd_acc       = req_rd_valid & req_rd_ready;

  assign req[NUM_FUNC]      = slot_v;
  assign cand_ctx[NUM_FUNC] = slot_ctx;
  assign cand_dat[NUM_FUNC] = 32'hFFFF_FFFF;

  for (genvar g = 0; g < NUM_FUNC; g++) begin : g_fn
    logic [CTX_W-1:0] cq_mem [OUTST_DEPTH];
    logic [QA:0]      cq_wp;
    logic [QA:0]      cq_rp;
    logic [CTX_W-1:0] rf_ctx [RSP_DEPTH];
    logic [31:0]      rf_dat [RSP_DEPTH];
    logic [RA:0]      rf_wp;
    logic [RA:0]      rf_rp;
    logic [WW-1:0]    wd;
    logic             cq_empty;
    logic             rf_empty;
    logic             rf_full;
    logic             rsp_in;
    logic             expire;
    logic             push_q;
    logic             pop_q;
    logic             rf_wr;
    logic [CTX_W-1:0] push_ctx;
    logic [31:0]      push_dat;

    assign cq_empty  = cq_wp == cq_rp;
    assign q_full[g] = (cq_wp ^ cq_rp) == {1'b1, {QA{1'b0}}};
    assign rf_empty  = rf_wp == rf_rp;
    assign rf_full   = (rf_wp ^ rf_rp) == {1'b1, {RA{1'b0}}};

    assign rsp_in = f_rsp_valid[g];
    assign push_q = rd_acc & rd_hit & (rd_fsel == 3'(g));
    // A real completion in the expiry cycle takes priority
    assign expire = ~cq_empty & ~rsp_in & (wd == WW'(TIMEOUT));
    assign pop_q  = ~cq_empty & (rsp_in | expire);

    assign push_ctx = rsp_in ? f_rsp_ctx[g*CTX_W +: CTX_W]
                             : cq_mem[cq_rp[QA-1:0]];
    assign push_dat = rsp_in ? f_rsp_data[g*32 +: 32]
                             : 32'hFFFF_FFFF;

    assign rf_pop[g]  = gnt_v & (gnt_idx == IW'(g));
    assign drop[g]    = pop_q & rf_full & ~rf_pop[g];
    assign rf_wr      = pop_q & ~drop[g];
    assign discard[g] = rsp_in & cq_empty;
    assign tmo[g]     = expire;

    assign req[g]      = ~rf_empty;
    assign cand_ctx[g] = rf_ctx[rf_rp[RA-1:0]];
    assign cand_dat[g] = rf_dat[rf_rp[RA-1:0]];

    // Queue/FIFO pointers and the per-function watchdog
    always_ff @(posedge clk_pcie or negedge rst_n) begin
      if (!rst_n) begin
        cq_wp <= '0;
        cq_rp <= '0;
        rf_wp <= '0;
        rf_rp <= '0;
        wd    <= '0;
      end else begin
        if (push_q)    cq_wp <= cq_wp + 1'b1;
        if (pop_q)     cq_rp <= cq_rp + 1'b1;
        if (rf_wr)     rf_wp <= rf_wp + 1'b1;
        if (rf_pop[g]) rf_rp <= rf_rp + 1'b1;
        if (cq_empty || rsp_in || expire) wd <= '0;
        else                              wd <= wd + 1'b1;
      end
    end

    // Storage needs no reset: pointers alone define what is valid
    always_ff @(posedge clk_pcie) begin
      if (push_q) cq_mem[cq_wp[QA-1:0]] <= req_rd_ctx;
      if (rf_wr) begin
        rf_ctx[rf_wp[RA-1:0]] <= push_ctx;
        rf_dat[rf_wp[RA-1:0]] <= push_dat;
      end
    end
  end

  // Round-robin search beginning at rr_ptr
  always_comb begin
    int idx;
    idx     = 0;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NR; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NR) idx = idx - NR;
      if (!gnt_v && req[IW'(idx)]) begin
        gnt_v   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  // Error-event tallies for the statistics counters
  always_comb begin
    err_inc = 5'(rd_acc & ~rd_hit);
    tmo_inc = '0;
    for (int f = 0; f < NUM_FUNC; f++) begin
      err_inc = err_inc + 5'(discard[f]) + 5'(drop[f]);
      tmo_inc = tmo_inc + 5'(tmo[f]);
    end
  end

  function automatic logic [15:0] sat_add(input logic [15:0] a,
                                          input logic [4:0]  b);
    logic [16:0] s;
    s = {1'b0, a} + {12'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Registered write/read dispatch onto the shared function buses
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      f_wr_addr  <= '0;
      f_wr_be    <= '0;
      f_wr_data  <= '0;
      f_wr_valid <= '0;
      f_rd_ctx   <= '0;
      f_rd_addr  <= '0;
      f_rd_valid <= '0;
    end else begin
      f_wr_valid <= '0;
      f_rd_valid <= '0;
      if (req_wr_valid && wr_hit) begin
        f_wr_addr  <= req_wr_addr & FMASK;
        f_wr_be    <= req_wr_be;
        f_wr_data  <= req_wr_data;
        f_wr_valid <= wr_oh[NUM_FUNC-1:0];
      end
      if (rd_acc && rd_hit) begin
        f_rd_ctx   <= req_rd_ctx;
        f_rd_addr  <= req_rd_addr & FMASK;
        f_rd_valid <= rd_oh[NUM_FUNC-1:0];
      end
    end
  end

  // Completion output register, RR pointer and local error slot
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_ctx   <= '0;
      rsp_data  <= '0;
      rr_ptr    <= '0;
      slot_v    <= 1'b0;
      slot_ctx  <= '0;
    end else begin
      rsp_valid <= gnt_v;
      if (gnt_v) begin
        rsp_ctx  <= cand_ctx[gnt_idx];
        rsp_data <= cand_dat[gnt_idx];
        rr_ptr   <= (gnt_idx == IW'(NUM_FUNC)) ? '0 : gnt_idx + 1'b1;
      end
      if (rd_acc && !rd_hit) begin
        slot_v   <= 1'b1;
        slot_ctx <= req_rd_ctx;
      end else if (gnt_v && gnt_idx == IW'(NUM_FUNC)) begin
        slot_v <= 1'b0;
      end
    end
  end

  // Saturating statistics
  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_drop <= '0;
      stat_rd_err  <= '0;
      stat_timeout <= '0;
    end else begin
      stat_wr_drop <= sat_add(stat_wr_drop, 5'(req_wr_valid & ~wr_hit));
      stat_rd_err  <= sat_add(stat_rd_err, err_inc);
      stat_timeout <= sat_add(stat_timeout, tmo_inc);
    end
  end

endmodule

// File: tb/tb_pcileech_bar_func_dispatch.sv
// Self-checking bench for pcileech_bar_func_dispatch: vector table plus
// hand sequences, completions checked through an expectation queue.
module tb_pcileech_bar_func_dispatch;

  localparam int NF = 8;
  localparam int CW = 88;
  localparam int T  = 1024;

  logic             clk_pcie = 1'b0;
  logic             rst_n;
  logic [NF-1:0]    func_enable;
  logic [31:0]      req_wr_addr;
  logic [3:0]       req_wr_be;
  logic [31:0]      req_wr_data;
  logic             req_wr_valid;
  logic [CW-1:0]    req_rd_ctx;
  logic [31:0]      req_rd_addr;
  logic             req_rd_valid;
  logic             req_rd_ready;
  logic [CW-1:0]    rsp_ctx;
  logic [31:0]      rsp_data;
  logic             rsp_valid;
  logic [31:0]      f_wr_addr;
  logic [3:0]       f_wr_be;
  logic [31:0]      f_wr_data;
  logic [NF-1:0]    f_wr_valid;
  logic [CW-1:0]    f_rd_ctx;
  logic [31:0]      f_rd_addr;
  logic [NF-1:0]    f_rd_valid;
  logic [NF*CW-1:0] f_rsp_ctx;
  logic [NF*32-1:0] f_rsp_data;
  logic [NF-1:0]    f_rsp_valid;
  logic [15:0]      stat_wr_drop;
  logic [15:0]      stat_rd_err;
  logic [15:0]      stat_timeout;

  pcileech_bar_func_dispatch #(
    .NUM_FUNC(NF), .FSEL_LSB(29), .CTX_W(CW),
    .OUTST_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT(T)
  ) dut (
    .clk_pcie(clk_pcie), .rst_n(rst_n), .func_enable(func_enable),
    .req_wr_addr(req_wr_addr), .req_wr_be(req_wr_be),
    .req_wr_data(req_wr_data), .req_wr_valid(req_wr_valid),
    .req_rd_ctx(req_rd_ctx), .req_rd_addr(req_rd_addr),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
    .rsp_ctx(rsp_ctx), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .f_wr_addr(f_wr_addr), .f_wr_be(f_wr_be), .f_wr_data(f_wr_data),
    .f_wr_valid(f_wr_valid), .f_rd_ctx(f_rd_ctx),
    .f_rd_addr(f_rd_addr), .f_rd_valid(f_rd_valid),
    .f_rsp_ctx(f_rsp_ctx), .f_rsp_data(f_rsp_data),
    .f_rsp_valid(f_rsp_valid), .stat_wr_drop(stat_wr_drop),
    .stat_rd_err(stat_rd_err), .stat_timeout(stat_timeout)
  );

  always #5 clk_pcie = ~clk_pcie;

  typedef struct {
    logic [CW-1:0] ctx;
    logic [31:0]   data;
  } exp_t;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  exp_v;
    logic [31:0] exp_addr;
    logic        drop;
  } vec_t;

  exp_t sb[$];
  exp_t ex;
  int   checks = 0;
  int   errors = 0;
  int   exp_wd = 0;
  int   exp_re = 0;

  task automatic tick();
    @(posedge clk_pcie);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [CW-1:0] c, input logic [31:0] d);
    exp_t e;
    e.ctx  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_rsp(input int f, input logic [CW-1:0] c,
                         input logic [31:0] d);
    f_rsp_ctx[f*CW +: CW] = c;
    f_rsp_data[f*32 +: 32] = d;
    f_rsp_valid[f] = 1'b1;
  endtask

  task automatic rd_req(input logic [31:0] a, input logic [CW-1:0] c);
    req_rd_addr  = a;
    req_rd_ctx   = c;
    req_rd_valid = 1'b1;
  endtask

  // Reads to f0..f2, simultaneous completions, checked in RR order
  task automatic rr_group(input int first, input logic [31:0] base);
    for (int k = 0; k < 3; k++) begin
      rd_req((32'(k) << 29) | (32'h40 + 32'(k) * 32'h100),
             88'hAB00 + 88'(k));
      if (k == 0) begin
        req_wr_addr  = 32'h0000_0008;
        req_wr_be    = 4'hF;
        req_wr_data  = 32'h5555_AAAA;
        req_wr_valid = 1'b1;
      end
      tick();
      req_rd_valid = 1'b0;
      req_wr_valid = 1'b0;
      chk("rd_strobe", f_rd_valid, 8'h01 << k);
      chk("rd_addr", f_rd_addr, 32'h40 + 32'(k) * 32'h100);
      chk("rd_ctx", f_rd_ctx, 88'hAB00 + 88'(k));
      if (k == 0) chk("wr_rd_same_cycle", f_wr_valid, 8'h01);
    end
    for (int k = 0; k < 3; k++)
      set_rsp(k, 88'hAB10 + 88'(k), base + 32'(k));
    for (int j = 0; j < 3; j++) begin
      int f;
      f = (first + j) % 3;
      expect_rsp(88'hAB10 + 88'(f), base + 32'(f));
    end
    tick();
    f_rsp_valid = '0;
    tick();
    chk("rr_v0", rsp_valid, 1'b1);
    tick();
    chk("rr_v1", rsp_valid, 1'b1);
    tick();
    chk("rr_v2", rsp_valid, 1'b1);
    tick();
    chk("rr_idle", rsp_valid, 1'b0);
  endtask

  // Scoreboard: every completion must match the queue head
  always @(negedge clk_pcie) begin
    if (rst_n && rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got ctx %0h data %0h expected none",
                 rsp_ctx, rsp_data);
      end else begin
        ex = sb.pop_front();
        chk("rsp_ctx", rsp_ctx, ex.ctx);
        chk("rsp_data", rsp_data, ex.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vt[7];
    int   n;
    int   m;

    vt[0] = '{1'b0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, 8'h07,
              8'h04, 32'h0000_0010, 1'b0};
    vt[1] = '{1'b0, 32'h0000_0020, 4'h3, 32'h1111_2222, 8'h07,
              8'h01, 32'h0000_0020, 1'b0};
    vt[2] = '{1'b0, 32'hE000_0FFC, 4'h1, 32'h3333_4444, 8'h07,
              8'h00, 32'h0, 1'b1};
    vt[3] = '{1'b0, 32'hE000_0FFC, 4'h1, 32'h3333_4444, 8'hFF,
              8'h80, 32'h0000_0FFC, 1'b0};
    vt[4] = '{1'b0, 32'h6000_1234, 4'h8, 32'h5555_6666, 8'hF7,
              8'h00, 32'h0, 1'b1};
    vt[5] = '{1'b1, 32'h2000_0040, 4'h0, 32'h0, 8'h01,
              8'h00, 32'h0, 1'b0};
    vt[6] = '{1'b1, 32'hA000_0000, 4'h0, 32'h0, 8'hDF,
              8'h00, 32'h0, 1'b0};

    rst_n        = 1'b0;
    func_enable  = '0;
    req_wr_addr  = '0;
    req_wr_be    = '0;
    req_wr_data  = '0;
    req_wr_valid = 1'b0;
    req_rd_ctx   = '0;
    req_rd_addr  = '0;
    req_rd_valid = 1'b0;
    f_rsp_ctx    = '0;
    f_rsp_data   = '0;
    f_rsp_valid  = '0;
    repeat (3) tick();
    chk("rst_ready", req_rd_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_wr_valid", f_wr_valid, 8'h00);
    chk("rst_rd_valid", f_rd_valid, 8'h00);
    chk("rst_stats", {stat_wr_drop, stat_rd_err, stat_timeout}, 48'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      func_enable = vt[i].en;
      if (vt[i].rd) begin
        rd_req(vt[i].addr, 88'hE000 + 88'(i));
        expect_rsp(88'hE000 + 88'(i), 32'hFFFF_FFFF);
        exp_re++;
      end else begin
        req_wr_addr  = vt[i].addr;
        req_wr_be    = vt[i].be;
        req_wr_data  = vt[i].data;
        req_wr_valid = 1'b1;
        if (vt[i].drop) exp_wd++;
      end
      tick();
      req_wr_valid = 1'b0;
      req_rd_valid = 1'b0;
      if (vt[i].rd) begin
        chk("vec_rd_valid", f_rd_valid, vt[i].exp_v);
        chk("vec_ready_busy", req_rd_ready, 1'b0);
      end else begin
        chk("vec_wr_valid", f_wr_valid, vt[i].exp_v);
        if (vt[i].exp_v != 8'h00) begin
          chk("vec_wr_addr", f_wr_addr, vt[i].exp_addr);
          chk("vec_wr_data", f_wr_data, vt[i].data);
          chk("vec_wr_be", f_wr_be, vt[i].be);
        end
      end
      chk("vec_wr_drop", stat_wr_drop, 16'(exp_wd));
      chk("vec_rd_err", stat_rd_err, 16'(exp_re));
      tick();
      chk("vec_strobe_1cyc", f_wr_valid | f_rd_valid, 8'h00);
      repeat (3) tick();
    end

    func_enable = 8'h01;
    rd_req(32'hA000_0100, 88'h00C0_FFEE_1234);
    expect_rsp(88'h00C0_FFEE_1234, 32'hFFFF_FFFF);
    exp_re++;
    tick();
    req_rd_valid = 1'b0;
    chk("err_no_strobe", f_rd_valid, 8'h00);
    chk("err_rsp_early", rsp_valid, 1'b0);
    chk("err_ready_low", req_rd_ready, 1'b0);
    chk("err_count", stat_rd_err, 16'(exp_re));
    tick();
    chk("err_rsp_2cyc", rsp_valid, 1'b1);
    chk("err_ready_back", req_rd_ready, 1'b1);
    repeat (2) tick();

    func_enable = 8'hFF;
    rr_group(0, 32'hA0);
    rd_req(32'h0000_0050, 88'hAB50);
    tick();
    req_rd_valid = 1'b0;
    set_rsp(0, 88'hAB51, 32'hB0);
    expect_rsp(88'hAB51, 32'hB0);
    tick();
    f_rsp_valid = '0;
    repeat (3) tick();
    rr_group(1, 32'hC0);

    set_rsp(5, 88'hDEAD, 32'h1234_5678);
    exp_re++;
    tick();
    f_rsp_valid = '0;
    chk("discard_err", stat_rd_err, 16'(exp_re));
    repeat (3) tick();

    for (int k = 0; k < 4; k++) begin
      chk("tmo_ready_pre", req_rd_ready, 1'b1);
      rd_req(32'h6000_0200 + 32'(k * 4), 88'hF000 + 88'(k));
      expect_rsp(88'hF000 + 88'(k), 32'hFFFF_FFFF);
      tick();
    end
    req_rd_valid = 1'b0;
    n = 3;
    chk("tmo_ready_full", req_rd_ready, 1'b0);
    rd_req(32'h6000_0300, 88'hF00F);
    tick();
    n++;
    req_rd_valid = 1'b0;
    chk("tmo_no_accept", f_rd_valid, 8'h00);
    while (n < 3 * T && !rsp_valid) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, T + 2);
    m = 0;
    while (m < 5 * T && (sb.size() != 0 || stat_timeout != 16'd4)) begin
      tick();
      m++;
    end
    chk("tmo_count", stat_timeout, 16'd4);
    chk("tmo_ready_after", req_rd_ready, 1'b1);
    chk("tmo_drained", sb.size(), 0);
    chk("tmo_rd_err", stat_rd_err, 16'(exp_re));

    for (int k = 0; k < 3; k++) begin
      rd_req(32'h8000_0000 + 32'(k * 4), 88'h7700 + 88'(k));
      tick();
    end
    req_rd_valid = 1'b0;
    set_rsp(4, 88'h7700, 32'h4444_0000);
    req_wr_addr  = 32'h8000_0004;
    req_wr_be    = 4'hF;
    req_wr_data  = 32'h1;
    req_wr_valid = 1'b1;
    tick();
    f_rsp_valid  = '0;
    req_wr_valid = 1'b0;
    chk("pre_rst_wr_valid", f_wr_valid, 8'h10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_valid", f_wr_valid, 8'h00);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_ctx", rsp_ctx, 88'h0);
    chk("mid_rst_ready", req_rd_ready, 1'b1);
    chk("mid_rst_stats", {stat_wr_drop, stat_rd_err, stat_timeout}, 48'h0);
    chk("mid_rst_wr_addr", f_wr_addr, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (T + 20) tick();
    chk("post_rst_timeout", stat_timeout, 16'd0);
    chk("post_rst_rd_err", stat_rd_err, 16'd0);
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);

    func_enable  = 8'h00;
    req_wr_addr  = 32'h0000_0100;
    req_wr_valid = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_below", stat_wr_drop, 16'hFFFE);
    for (int i = 65534; i < 70000; i++) tick();
    req_wr_valid = 1'b0;
    chk("sat_hold", stat_wr_drop, 16'hFFFF);
    chk("sat_no_strobe", f_wr_valid, 8'h00);
    repeat (3) tick();
    chk("sb_empty_end", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
